// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } fetch_state_e;

    localparam int unsigned PcStep          = 4;
    localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;
    localparam logic [1:0]  AlignMask       = 2'b11;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register: next-PC selection between redirect, sequential advance and hold,
// with registered wrap and misaligned-redirect pulses.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned      AddrW   = 5,
    parameter logic [AddrW-1:0] ResetPc = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    input  logic             redirect_i,
    input  logic [AddrW-1:0] redirect_pc_i,
    output logic [AddrW-1:0] pc_o,
    output logic             wrap_o,
    output logic             align_err_o
);

    localparam logic [AddrW-1:0] Step = AddrW'(PcStep);
    localparam logic [AddrW-1:0] Mask = AddrW'(AlignMask);

    logic [AddrW-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic             align_err_q, align_err_d;
    logic [AddrW:0]   pc_inc;

    // Carry out of the increment marks the 2^AddrW-4 -> 0 step.
    assign pc_inc = {1'b0, pc_q} + {1'b0, Step};

    always_comb begin
        pc_d        = pc_q;
        wrap_d      = 1'b0;
        align_err_d = 1'b0;
        if (redirect_i) begin
            pc_d        = redirect_pc_i & ~Mask;
            align_err_d = |(redirect_pc_i & Mask);
        end else if (advance_i) begin
            pc_d   = pc_inc[AddrW-1:0];
            wrap_d = pc_inc[AddrW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= ResetPc;
            wrap_q      <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wrap_q      <= wrap_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc_o        = pc_q;
    assign wrap_o      = wrap_q;
    assign align_err_o = align_err_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch FSM, instruction register with valid/ready handoff to decode,
// and a saturating count of instructions accepted by decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      AddrW    = 5,
    parameter int unsigned      DataW    = 32,
    parameter logic [AddrW-1:0] ResetPc  = '0,
    parameter logic [DataW-1:0] HaltWord = DataW'(HaltWordDefault)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             load_mode_i,
    output logic [AddrW-1:0] mem_add_o,
    input  logic [DataW-1:0] mem_prog_i,
    input  logic             redirect_valid_i,
    input  logic [AddrW-1:0] redirect_pc_i,
    output logic [DataW-1:0] ir_o,
    output logic [AddrW-1:0] ir_pc_o,
    output logic             ir_valid_o,
    input  logic             ir_ready_i,
    output logic             halted_o,
    output logic             align_err_o,
    output logic             wrap_o,
    output logic [15:0]      fetch_cnt_o
);

    fetch_state_e     state_q;
    logic [DataW-1:0] ir_q;
    logic [AddrW-1:0] ir_pc_q;
    logic             ir_valid_q;
    logic [15:0]      fetch_cnt_q;
    logic [AddrW-1:0] pc;
    logic             redir_go;
    logic             capture;
    logic             accept;

    // Load mode masks a redirect; a redirect masks both capture and consume.
    assign redir_go = redirect_valid_i && !load_mode_i;
    assign capture  = (state_q == StRun) && run_i && !load_mode_i && !redir_go
                      && (!ir_valid_q || ir_ready_i);
    assign accept   = ir_valid_q && ir_ready_i && !load_mode_i && !redir_go;

    fetch_pc_gen #(
        .AddrW  (AddrW),
        .ResetPc(ResetPc)
    ) u_pc_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .advance_i    (capture),
        .redirect_i   (redir_go),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (pc),
        .wrap_o       (wrap_o),
        .align_err_o  (align_err_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            if (accept && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (load_mode_i) begin
                ir_valid_q <= 1'b0;
                if (state_q != StHalted) begin
                    state_q <= StIdle;
                end
            end else if (redir_go) begin
                ir_valid_q <= 1'b0;
                state_q    <= run_i ? StRun : StIdle;
            end else begin
                if (capture) begin
                    ir_q       <= mem_prog_i;
                    ir_pc_q    <= pc;
                    ir_valid_q <= 1'b1;
                end else if (accept) begin
                    ir_valid_q <= 1'b0;
                end
                case (state_q)
                    StIdle: begin
                        if (run_i) state_q <= StRun;
                    end
                    StRun: begin
                        if (!run_i) begin
                            state_q <= StIdle;
                        end else if (capture && (mem_prog_i == HaltWord)) begin
                            state_q <= StHalted;
                        end
                    end
                    StHalted: state_q <= StHalted;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    assign mem_add_o   = pc;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = ir_valid_q;
    assign halted_o    = (state_q == StHalted);
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table for streaming/stall, hand sequences
// for redirect, halt, load-mode lockout, reset priority and counter saturation.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        run;
    logic        load_mode;
    logic [4:0]  mem_add;
    logic [31:0] mem_prog;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic [31:0] ir;
    logic [4:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        halted;
    logic        align_err;
    logic        wrap;
    logic [15:0] fetch_cnt;

    logic [31:0] mem [8];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        run;
        logic        rdy;
        logic        valid;
        logic [31:0] ir;
        logic [4:0]  irpc;
        logic [4:0]  add;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];

    instr_fetch u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .run_i           (run),
        .load_mode_i     (load_mode),
        .mem_add_o       (mem_add),
        .mem_prog_i      (mem_prog),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .ir_o            (ir),
        .ir_pc_o         (ir_pc),
        .ir_valid_o      (ir_valid),
        .ir_ready_i      (ir_ready),
        .halted_o        (halted),
        .align_err_o     (align_err),
        .wrap_o          (wrap),
        .fetch_cnt_o     (fetch_cnt)
    );

    assign mem_prog = mem[mem_add[4:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic v, input int i,
                                input int ip, input int a, input logic w);
        vec_t t;
        t.run   = r;
        t.rdy   = rd;
        t.valid = v;
        t.ir    = i;
        t.irpc  = ip[4:0];
        t.add   = a[4:0];
        t.wrap  = w;
        return t;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " mem_add"}, mem_add, 0);
        chk({tag, " ir"}, ir, 0);
        chk({tag, " ir_pc"}, ir_pc, 0);
        chk({tag, " ir_valid"}, ir_valid, 0);
        chk({tag, " halted"}, halted, 0);
        chk({tag, " align_err"}, align_err, 0);
        chk({tag, " wrap"}, wrap, 0);
        chk({tag, " fetch_cnt"}, fetch_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'(i * 4);
        rst = 1'b1; run = 1'b0; load_mode = 1'b0; ir_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;

        // Streaming with wrap, then a 3-cycle stall holding ir=8.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 1, 1, i * 4, i * 4, (i * 4 + 4) % 32, (i == 7) ? 1'b1 : 1'b0));
        end
        vecs.push_back(mk(1, 1, 1, 0, 0, 4, 0));
        vecs.push_back(mk(1, 1, 1, 4, 4, 8, 0));
        vecs.push_back(mk(1, 1, 1, 8, 8, 12, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 8, 8, 12, 0));
        vecs.push_back(mk(1, 1, 1, 12, 12, 16, 0));
        vecs.push_back(mk(1, 1, 1, 16, 16, 20, 0));

        foreach (vecs[i]) begin
            run      = vecs[i].run;
            ir_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d ir_valid", i), ir_valid, vecs[i].valid);
            chk($sformatf("v%0d ir", i), ir, vecs[i].ir);
            chk($sformatf("v%0d ir_pc", i), ir_pc, vecs[i].irpc);
            chk($sformatf("v%0d mem_add", i), mem_add, vecs[i].add);
            chk($sformatf("v%0d wrap", i), wrap, vecs[i].wrap);
        end
        chk("stream fetch_cnt", fetch_cnt, 12);

        // Redirect flushes the IR; misaligned target is rounded down and flagged.
        redirect_valid = 1'b1; redirect_pc = 5'd4; tick(); redirect_valid = 1'b0;
        chk("redir4 ir_valid", ir_valid, 0);
        chk("redir4 mem_add", mem_add, 4);
        tick();
        chk("redir4 ir", ir, 4);
        chk("redir4 ir_valid1", ir_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 5'd20; tick(); redirect_valid = 1'b0;
        chk("redir20 ir_valid", ir_valid, 0);
        chk("redir20 mem_add", mem_add, 20);
        chk("redir20 align_err", align_err, 0);
        tick();
        chk("redir20 ir", ir, 20);
        chk("redir20 ir_pc", ir_pc, 20);
        chk("redir20 ir_valid1", ir_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 5'd22; tick(); redirect_valid = 1'b0;
        chk("redir22 align_err", align_err, 1);
        chk("redir22 mem_add", mem_add, 20);
        chk("redir22 ir_valid", ir_valid, 0);
        tick();
        chk("redir22 align_err end", align_err, 0);
        chk("redir22 ir", ir, 20);
        chk("redir22 ir_pc", ir_pc, 20);

        // Halt word at byte 16.
        mem[4] = 32'hFFFF_FFFF;
        redirect_valid = 1'b1; redirect_pc = 5'd12; tick(); redirect_valid = 1'b0;
        chk("halt mem_add12", mem_add, 12);
        tick();
        chk("halt ir12", ir, 12);
        tick();
        chk("halt ir", ir, 32'hFFFF_FFFF);
        chk("halt ir_pc", ir_pc, 16);
        chk("halt ir_valid", ir_valid, 1);
        chk("halt mem_add20", mem_add, 20);
        tick();
        chk("halt halted", halted, 1);
        chk("halt consumed", ir_valid, 0);
        repeat (2) tick();
        chk("halt frozen mem_add", mem_add, 20);
        chk("halt frozen ir_valid", ir_valid, 0);
        chk("halt frozen halted", halted, 1);
        redirect_valid = 1'b1; redirect_pc = 5'd0; tick(); redirect_valid = 1'b0;
        chk("unhalt halted", halted, 0);
        chk("unhalt mem_add", mem_add, 0);
        tick();
        chk("unhalt ir", ir, 0);
        chk("unhalt ir_valid", ir_valid, 1);
        chk("unhalt mem_add4", mem_add, 4);
        mem[4] = 32'd16;

        // Load-mode lockout mid-stream.
        tick();
        chk("load pre ir", ir, 4);
        load_mode = 1'b1; tick();
        chk("load ir_valid", ir_valid, 0);
        chk("load mem_add", mem_add, 8);
        tick();
        chk("load hold ir_valid", ir_valid, 0);
        chk("load hold mem_add", mem_add, 8);
        load_mode = 1'b0; tick();
        chk("load drop ir_valid", ir_valid, 0);
        tick();
        chk("load resume ir", ir, 8);
        chk("load resume ir_pc", ir_pc, 8);
        chk("load resume ir_valid", ir_valid, 1);
        chk("load resume mem_add", mem_add, 12);

        // Reset beats a simultaneous misaligned redirect and handshake.
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd22; ir_ready = 1'b1;
        tick();
        chk_reset("rst2");
        rst = 1'b0; redirect_valid = 1'b0;

        // Saturating fetch counter.
        repeat (100) tick();
        chk("cnt 98", fetch_cnt, 98);
        repeat (70000) tick();
        chk("cnt sat", fetch_cnt, 16'hFFFF);
        chk("cnt sat ir_valid", ir_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
